// File: rtl/onehot_decoder_seq_if.sv
// Code-input handshake for onehot_decoder_seq.
// A code on `in` transfers on a rising edge where both in_valid and in_ready are high.
interface onehot_decoder_seq_if;
    logic       in_valid;
    logic [2:0] in;
    logic       in_ready;

    modport master (output in_valid, output in, input in_ready);
    modport slave  (input in_valid, input in, output in_ready);
endinterface

// File: rtl/onehot_decoder_seq.sv
// Sequenced 3-to-8 decoder: buffers codes in a small FIFO and plays each one
// as a registered one-hot strobe held HOLD cycles, back-to-back.
module onehot_decoder_seq #(
    parameter int HOLD  = 4,
    parameter int DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    onehot_decoder_seq_if.slave  bus,
    output logic [7:0]           out,
    output logic                 out_valid,
    output logic                 overflow,
    output logic                 state_dbg
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic {IDLE, DRIVE} state_t;

    state_t         state, state_next;
    logic [2:0]     mem [DEPTH];
    logic [AW-1:0]  wr_ptr, rd_ptr;
    logic [CW-1:0]  count;
    logic [7:0]     cnt;
    logic           full, empty, push, pop, load, clear, dec;

    assign full         = (count == CW'(DEPTH));
    assign empty        = (count == '0);
    assign bus.in_ready = en && !full;
    assign push         = bus.in_valid && bus.in_ready;
    assign state_dbg    = (state == DRIVE);

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= bus.in;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
            if (bus.in_valid && en && full) begin
                overflow <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // A pop always coincides with loading the popped code onto the output.
    always_comb begin
        state_next = state;
        pop        = 1'b0;
        load       = 1'b0;
        clear      = 1'b0;
        dec        = 1'b0;
        if (!en) begin
            state_next = IDLE;
            clear      = 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (!empty) begin
                        pop        = 1'b1;
                        load       = 1'b1;
                        state_next = DRIVE;
                    end
                end
                DRIVE: begin
                    if (cnt != 8'd0) begin
                        dec = 1'b1;
                    end else if (!empty) begin
                        pop  = 1'b1;
                        load = 1'b1;
                    end else begin
                        clear      = 1'b1;
                        state_next = IDLE;
                    end
                end
                default: begin
                    clear      = 1'b1;
                    state_next = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out       <= 8'd0;
            out_valid <= 1'b0;
            cnt       <= 8'd0;
        end else if (load) begin
            out       <= 8'd1 << mem[rd_ptr];
            out_valid <= 1'b1;
            cnt       <= 8'(HOLD - 1);
        end else if (clear) begin
            out       <= 8'd0;
            out_valid <= 1'b0;
            cnt       <= 8'd0;
        end else if (dec) begin
            cnt <= cnt - 8'd1;
        end
    end
endmodule

// File: tb/tb_onehot_decoder_seq.sv
// Randomized scoreboard bench for onehot_decoder_seq against a queue-based
// reference model of the FIFO occupancy and strobe timing.
module tb_onehot_decoder_seq;
    localparam int HOLD  = 4;
    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       en  = 1'b0;
    logic [7:0] out;
    logic       out_valid;
    logic       overflow;
    logic       state_dbg;

    onehot_decoder_seq_if bus ();

    onehot_decoder_seq #(.HOLD(HOLD), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .bus       (bus),
        .out       (out),
        .out_valid (out_valid),
        .overflow  (overflow),
        .state_dbg (state_dbg)
    );

    always #5 clk = ~clk;

    // Reference model: codes waiting, the strobe being played and its cycles left.
    logic [7:0] exp_q[$];
    int         m_count   = 0;
    int         m_left    = 0;
    bit         m_playing = 1'b0;
    bit         m_start   = 1'b0;
    bit         m_ovf     = 1'b0;
    bit         started   = 1'b0;
    logic [7:0] cur_exp   = 8'd0;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    always @(posedge clk) begin
        bit full_pre, acc, took;
        if (!rst) begin
            full_pre = (m_count == DEPTH);
            acc      = bus.in_valid && en && !full_pre;
            took     = 1'b0;
            if (bus.in_valid && en && full_pre) m_ovf = 1'b1;
            m_start = 1'b0;
            if (!en) begin
                m_playing = 1'b0;
                m_left    = 0;
            end else if (m_playing && m_left > 1) begin
                m_left--;
            end else if (m_count > 0) begin
                took      = 1'b1;
                m_playing = 1'b1;
                m_left    = HOLD;
                m_start   = 1'b1;
            end else begin
                m_playing = 1'b0;
                m_left    = 0;
            end
            if (acc) begin
                m_count++;
                exp_q.push_back(8'd1 << bus.in);
            end
            if (took) m_count--;
        end
    end

    always @(negedge clk) begin
        if (!rst && started) begin
            check("in_ready", {7'd0, bus.in_ready}, {7'd0, en && (m_count < DEPTH)});
            check("overflow", {7'd0, overflow}, {7'd0, m_ovf});
            check("out_valid", {7'd0, out_valid}, {7'd0, m_playing});
            check("valid_vs_out", {7'd0, out_valid}, {7'd0, out != 8'd0});
            if (m_start) begin
                if (exp_q.size() == 0) begin
                    check("strobe_unexpected", out, 8'd0);
                end else begin
                    cur_exp = exp_q.pop_front();
                    check("strobe_start", out, cur_exp);
                end
            end else if (m_playing) begin
                check("strobe_hold", out, cur_exp);
            end else begin
                check("out_idle", out, 8'd0);
            end
        end
    end

    task automatic do_reset();
        @(posedge clk);
        #2;
        rst       = 1'b1;
        exp_q.delete();
        m_count   = 0;
        m_left    = 0;
        m_playing = 1'b0;
        m_start   = 1'b0;
        m_ovf     = 1'b0;
        cur_exp   = 8'd0;
        #1;
        check("rst_out", out, 8'd0);
        check("rst_out_valid", {7'd0, out_valid}, 8'd0);
        check("rst_overflow", {7'd0, overflow}, 8'd0);
        repeat (2) @(posedge clk);
        #2;
        rst     = 1'b0;
        started = 1'b1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_code(input logic [2:0] code);
        bus.in_valid = 1'b1;
        bus.in       = code;
        tick();
        bus.in_valid = 1'b0;
    endtask

    task automatic drain();
        bit done;
        done = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if (exp_q.size() == 0 && !m_playing) begin
                done = 1'b1;
                break;
            end
            tick();
        end
        check("drain_timeout", {7'd0, done}, 8'd1);
    endtask

    initial begin
        bus.in_valid = 1'b0;
        bus.in       = 3'd0;
        do_reset();
        en = 1'b1;
        tick();
        check("ready_after_rst", {7'd0, bus.in_ready}, 8'd1);

        write_code(3'd5);
        drain();

        bus.in_valid = 1'b1;
        foreach (exp_q[i]) begin end
        bus.in = 3'd0; tick();
        bus.in = 3'd1; tick();
        bus.in = 3'd7; tick();
        bus.in_valid = 1'b0;
        drain();

        // Six back-to-back writes: one pops immediately, four fill, the sixth overflows.
        bus.in_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            bus.in = 3'($urandom_range(0, 7));
            tick();
        end
        bus.in_valid = 1'b0;
        check("overflow_set", {7'd0, overflow}, 8'd1);
        drain();

        bus.in_valid = 1'b1;
        bus.in = 3'd3; tick();
        bus.in = 3'd1; tick();
        bus.in = 3'd6; tick();
        en = 1'b0;
        repeat (4) tick();
        bus.in_valid = 1'b0;
        en = 1'b1;
        drain();

        bus.in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            bus.in = 3'($urandom_range(0, 7));
            tick();
        end
        bus.in_valid = 1'b0;
        tick();
        do_reset();
        tick();
        write_code(3'd2);
        tick();
        check("fresh_code", out, 8'h04);
        drain();

        for (int i = 0; i < 400; i++) begin
            bus.in_valid = 1'($urandom_range(0, 1));
            bus.in       = 3'($urandom_range(0, 7));
            en           = ($urandom_range(0, 15) != 0);
            tick();
        end
        bus.in_valid = 1'b0;
        en = 1'b1;
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/onehot_decoder_seq.md
# onehot_decoder_seq

Sequenced 3-to-8 decoder: the receiving end of the 8-to-3 encoder path. It accepts 3-bit codes through a valid/ready handshake and buffers them in a small FIFO. Each code is then driven as a registered one-hot byte held for a programmable number of cycles, back-to-back with no gap. It sits downstream of the encoder and turns a stream of codes into timed one-hot strobes for select/LED-style loads.

## Interface
- HOLD, 4: cycles each one-hot value is held on `out`; legal range 1..255.
- DEPTH, 4: FIFO entries; power of two, 2..16.
- clk  in  1  single clock; all state updates on its rising edge.
- rst  in  1  reset, asynchronous and active-high.
- en  in  1  block enable; low flushes output and blocks writes.
- in_valid  in  1  code on `in` is offered this cycle.
- in  in  3  code to decode (0..7).
- in_ready  out  1  combinational: `en && !full`.
- out  out  8  registered one-hot output, `1 << code`, or 0.
- out_valid  out  1  registered, high exactly when `out` is non-zero.
- overflow  out  1  sticky: a write was attempted while FIFO full.

## Operation
- Reset values: `out = 0`, `out_valid = 0`, `overflow = 0`, FIFO empty (pointers and count 0), state IDLE, hold counter 0. `in_ready` follows `en` once reset is released.
- Write: a code is accepted on a rising edge when `in_valid && in_ready`.
- `in_valid && en && full` drops the code and sets `overflow`. `overflow` clears only on `rst`.
- `in_valid` while `en = 0` is ignored and does not set overflow.
- FIFO: circular buffer of DEPTH x 3 bits with a count register of width log2(DEPTH)+1. Pointers wrap from DEPTH-1 to 0.
- A pop in the same cycle does not free a slot for a same-cycle push. `in_ready` depends only on the registered full flag.
- FSM, IDLE:
  - If `en` and FIFO not empty: pop the head, load `out <= 1 << head`, set `out_valid`, load `cnt <= HOLD-1`, go to DRIVE.
  - Otherwise stay in IDLE with `out = 0`.
- FSM, DRIVE:
  - While `cnt != 0`: decrement `cnt` and hold `out`.
  - At `cnt == 0`, if `en` and FIFO not empty: pop and load the next code in the same edge (no idle cycle), reload `cnt`, stay in DRIVE.
  - At `cnt == 0`, otherwise: `out <= 0`, `out_valid <= 0`, go to IDLE.
- `en` deasserted in any state: on the next edge `out <= 0`, `out_valid <= 0`, state becomes IDLE, and the in-flight code is discarded. FIFO contents are retained and resume draining when `en` returns high.
- `rst` asserted mid-hold: all outputs clear immediately (asynchronously) and queued codes are lost.
- Width rule: `cnt` is 8 bits. HOLD=1 yields a single-cycle strobe per code.

## Timing
- A code accepted on edge E into an empty FIFO with the FSM in IDLE:
  - `out` is valid after edge E+1.
  - It is held for exactly HOLD cycles.
  - It clears at edge E+1+HOLD if nothing is queued.
- Queued codes appear consecutively; each lasts HOLD cycles with zero gap.
- Sustained throughput is one code per HOLD cycles. Input bursts of up to DEPTH codes are absorbed without loss.
- `in_ready` falls in the cycle after the write that fills the FIFO. It rises in the cycle after the pop that un-fills it.
- No combinational path from `in`/`in_valid` to `out`.

## Test plan
- Reset/idle: assert `rst` mid-cycle -> `out = 8'h00`, `out_valid = 0`, `overflow = 0` immediately. After release with `en = 1` -> `in_ready = 1`.
- Single code (HOLD=4): write 3'd5 at edge E -> `out = 8'h20` from E+1 through E+4, `8'h00` after E+5. `out_valid` matches.
- Burst: write 0, 1, 7 on consecutive edges -> `out` sequence `8'h01`x4, `8'h02`x4, `8'h80`x4 with no zero cycle between, then 0.
- Full/overflow (DEPTH=4, HOLD=8):
  - Write 5 codes on consecutive edges -> first code pops at E+1, so 4 more fill the FIFO, and `in_ready = 0`.
  - A 6th write sets `overflow = 1` and is dropped.
  - All accepted codes still emerge in order; `overflow` stays 1.
- Enable drop: drop `en` mid-hold of `8'h08` with 2 codes queued -> `out = 0` next edge, writes refused, no overflow. Raise `en` -> the 2 queued codes play out in order.
- Reset mid-operation: `rst` during a burst -> `out = 0` at once. After release, the FIFO is empty and a fresh write of 3'd2 yields `8'h04` one edge later.
